// File: rtl/sdi_pkg.sv
// sdi_pkg: TRS constants, XYZ bit positions and detector state encoding.
package sdi_pkg;
  localparam logic [9:0] TRS_ONES = 10'h3FF;
  localparam logic [9:0] TRS_ZEROS = 10'h000;
  localparam int F_BIT = 8;
  localparam int V_BIT = 7;
  localparam int H_BIT = 6;
  localparam int P3_BIT = 5;
  localparam int P2_BIT = 4;
  localparam int P1_BIT = 3;
  localparam int P0_BIT = 2;
  typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED, ST_HOLDOFF} state_t;
  function automatic logic xyz_ok(input logic [9:0] w);
    logic f, v, h;
    f = w[F_BIT];
    v = w[V_BIT];
    h = w[H_BIT];
    return w[9] && w[1:0] == 2'b00 && w[P3_BIT] == (v ^ h) && w[P2_BIT] == (f ^ h) &&
           w[P1_BIT] == (f ^ v) && w[P0_BIT] == (f ^ v ^ h);
  endfunction
endpackage

// File: rtl/sdi_trs_matcher.sv
// sdi_trs_matcher: preamble shift register; flags a TRS on the XYZ word.
// SDI_XYZ_CHECK_EN adds the XYZ protection-bit check.
module sdi_trs_matcher
  import sdi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [9:0] data,
  input  logic       valid,
  output logic       hit,
  output logic [2:0] fvh
);
  logic [29:0] sr;
  logic ok;
`ifdef SDI_XYZ_CHECK_EN
  assign ok = xyz_ok(data);
`else
  assign ok = 1'b1;
`endif
  assign hit = valid && !clr && ok && sr == {TRS_ONES, TRS_ZEROS, TRS_ZEROS};
  assign fvh = data[F_BIT:H_BIT];
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (clr) sr <= '0;
    else if (valid) sr <= {sr[19:0], data};
endmodule

// File: rtl/sdi_trs_detector.sv
// sdi_trs_detector: TRS-based word-alignment monitor driving aligner slips.
// Optional XYZ validation via SDI_XYZ_CHECK_EN (see sdi_trs_matcher).
module sdi_trs_detector
  import sdi_pkg::*;
#(
  parameter int TIMEOUT  = 4096,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  parameter int HOLDOFF  = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [9:0] data_i,
  input  logic       valid_i,
  input  logic       detector_rst_i,
  output logic       n_align_o,
  output logic       locked_o,
  output logic       trs_o,
  output logic [2:0] fvh_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  state_t state, nxt;
  logic [CW-1:0] word_cnt;
  logic [GW-1:0] good, good_n;
  logic [MW-1:0] miss, miss_n;
  logic [HW-1:0] hold_cnt;
  logic hit, tmo, fire, hold;
  logic [2:0] fvh;
  assign hold = state == ST_HOLDOFF;
  // the shift register is held clear while bitslips settle
  sdi_trs_matcher u_matcher (
    .clk(sys_clk), .rst(sys_rst), .clr(detector_rst_i || hold),
    .data(data_i), .valid(valid_i), .hit(hit), .fvh(fvh)
  );
  assign tmo = valid_i && !hit && !hold && word_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    good_n = good;
    miss_n = miss;
    fire = 1'b0;
    case (state)
      ST_SEARCH:
        if (hit) begin
          nxt = ST_ACQUIRE;
          good_n = GW'(1);
        end else if (tmo) begin
          fire = 1'b1;
          nxt = ST_HOLDOFF;
        end
      ST_ACQUIRE:
        if (hit) begin
          good_n = good + GW'(1);
          nxt = good_n == GW'(LOCK_CNT) ? ST_LOCKED : ST_ACQUIRE;
        end else if (tmo) begin
          fire = 1'b1;
          nxt = ST_HOLDOFF;
        end
      ST_LOCKED:
        if (hit) miss_n = '0;
        else if (tmo) begin
          miss_n = miss + MW'(1);
          fire = miss_n == MW'(MISS_MAX);
          nxt = fire ? ST_HOLDOFF : ST_LOCKED;
        end
      ST_HOLDOFF:
        nxt = hold_cnt == HW'(HOLDOFF - 1) ? ST_SEARCH : ST_HOLDOFF;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst || detector_rst_i) begin
      state <= ST_SEARCH;
      word_cnt <= '0;
      good <= '0;
      miss <= '0;
      hold_cnt <= '0;
      n_align_o <= 1'b0;
      locked_o <= 1'b0;
      trs_o <= 1'b0;
      fvh_o <= '0;
    end else begin
      state <= nxt;
      good <= hold ? '0 : good_n;
      miss <= hold ? '0 : miss_n;
      hold_cnt <= hold ? hold_cnt + HW'(1) : '0;
      word_cnt <= (hold || hit || tmo) ? '0 : valid_i ? word_cnt + CW'(1) : word_cnt;
      n_align_o <= fire;
      locked_o <= state == ST_LOCKED && nxt == ST_LOCKED;
      trs_o <= hit;
      if (hit) fvh_o <= fvh;
    end
endmodule

// File: tb/tb_sdi_trs_detector.sv
// tb_sdi_trs_detector: scoreboard bench; expected fvh queued per driven TRS.
module tb_sdi_trs_detector;
  import sdi_pkg::*;
  logic sys_clk = 0, sys_rst = 1, valid_i = 0, detector_rst_i = 0;
  logic [9:0] data_i = '0;
  logic n_align_o, locked_o, trs_o;
  logic [2:0] fvh_o;
  int total = 0, bad = 0, cyc = 0, trs_n = 0, trs_since = 0, last_trs_cyc = 0, last_xyz = 0;
  int na_cyc[$];
  logic na_lock[$];
  logic [2:0] exp_q[$];
  logic locked_q = 0, na_q = 0;
  int n0;

  sdi_trs_detector dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_i(data_i), .valid_i(valid_i),
    .detector_rst_i(detector_rst_i), .n_align_o(n_align_o), .locked_o(locked_o),
    .trs_o(trs_o), .fvh_o(fvh_o)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (trs_o) begin
      trs_n++;
      trs_since++;
      last_trs_cyc = cyc;
      if (exp_q.size() == 0) chk("trs_unexp", 1, 0);
      else chk("fvh", fvh_o, exp_q.pop_front());
    end
    if (locked_o && !locked_q) begin
      chk("lock_lat", cyc - last_trs_cyc, 1);
      chk("lock_trs", trs_since, 4);
    end
    if (n_align_o) begin
      chk("na_width", na_q, 0);
      chk("na_locked", locked_o, 0);
      na_cyc.push_back(cyc);
      na_lock.push_back(locked_q);
    end
    locked_q = locked_o;
    na_q = n_align_o;
  end

  function automatic logic [9:0] xyz(input logic [2:0] f);
    return {1'b1, f, f[1] ^ f[0], f[2] ^ f[0], f[2] ^ f[1], ^f, 2'b00};
  endfunction

  task word(input logic [9:0] d, input logic v = 1'b1);
    data_i = d;
    valid_i = v;
    @(posedge sys_clk);
    #1;
  endtask

  task filler(input int n);
    for (int i = 0; i < n; i++) word(10'($urandom_range(1, 10'h3FE)));
  endtask

  task line(input logic [2:0] f, input int n);
    word(TRS_ONES);
    word(10'h155, 1'b0);
    word(TRS_ZEROS);
    word(TRS_ZEROS);
    exp_q.push_back(f);
    last_xyz = cyc + 1;
    word(xyz(f));
    filler(n - 4);
  endtask

  task rst_dut;
    sys_rst = 1;
    word(0, 0);
    sys_rst = 0;
    exp_q.delete();
    trs_since = 0;
  endtask

  initial begin
    repeat (2) word(0, 0);
    chk("rst_na", n_align_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_trs", trs_o, 0);
    chk("rst_fvh", fvh_o, 0);
    sys_rst = 0;
    for (int i = 0; i < 5; i++) line(3'(i + 1), 3300);
    chk("t2_trs", trs_n, 5);
    chk("t2_locked", locked_o, 1);
    chk("t2_na", na_cyc.size(), 0);
    chk("t2_fvh_hold", fvh_o, 5);
    filler(10);
    #2 sys_rst = 1;
    #1;
    chk("t1_locked", locked_o, 0);
    chk("t1_fvh", fvh_o, 0);
    chk("t1_trs", trs_o, 0);
    chk("t1_na", n_align_o, 0);
    @(posedge sys_clk);
    #1 sys_rst = 0;
    exp_q.delete();
    trs_since = 0;
    chk("t1_state", dut.state, ST_SEARCH);
    n0 = na_cyc.size();
    last_xyz = cyc;
    filler(4096 + 64 + 4096 + 10);
    chk("t3_cnt", na_cyc.size() - n0, 2);
    chk("t3_first", na_cyc[n0] - last_xyz, 4096);
    chk("t3_period", na_cyc[n0+1] - na_cyc[n0], 4160);
    rst_dut();
    n0 = na_cyc.size();
    for (int i = 0; i < 4; i++) line(3'(i), 100);
    chk("t4_locked", locked_o, 1);
    filler(4100);
    chk("t4_miss1_na", na_cyc.size() - n0, 0);
    chk("t4_miss1_locked", locked_o, 1);
    filler(4100);
    chk("t4_cnt", na_cyc.size() - n0, 1);
    chk("t4_at", na_cyc[n0] - last_xyz, 8192);
    chk("t4_lock_before", na_lock[n0], 1);
    chk("t4_unlocked", locked_o, 0);
    rst_dut();
    line(3'd6, 100);
    line(3'd7, 100);
    detector_rst_i = 1;
    word(0, 0);
    detector_rst_i = 0;
    trs_since = 0;
    chk("t5_state", dut.state, ST_SEARCH);
    for (int i = 0; i < 3; i++) line(3'(i + 2), 100);
    chk("t5_not_locked", locked_o, 0);
    line(3'd3, 100);
    chk("t5_locked", locked_o, 1);
    rst_dut();
    n0 = trs_n;
    word(TRS_ONES);
    word(TRS_ZEROS);
    word(TRS_ZEROS);
`ifndef SDI_XYZ_CHECK_EN
    exp_q.push_back(3'b000);
`endif
    word(10'h200);
    filler(5);
`ifdef SDI_XYZ_CHECK_EN
    chk("t6_trs", trs_n - n0, 0);
`else
    chk("t6_trs", trs_n - n0, 1);
`endif
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
